// File: rtl/key_cmd_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : key_cmd_decoder
//  Description : Debounces a raw HID keycode, maps it to a game command,
//                auto-repeats held movement keys on frame ticks, and queues
//                commands in a 2-entry valid/ready FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_cmd_decoder #(
    parameter int DEB_CYCLES   = 50000,
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 6
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       frame_clk,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    output logic       overflow,
    output logic [7:0] stable_key
);

    // Debounce counter sized to hold the saturation value DEB_CYCLES
    localparam int              c_DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);
    localparam logic [c_DEB_W-1:0] c_DEB_SAT  = c_DEB_W'(DEB_CYCLES);
    localparam logic [7:0]      c_REP_DELAY = 8'(REPEAT_DELAY);
    localparam logic [7:0]      c_REP_RATE  = 8'(REPEAT_RATE);

    // Command encodings
    localparam logic [2:0] c_CMD_UP    = 3'd0;
    localparam logic [2:0] c_CMD_LEFT  = 3'd1;
    localparam logic [2:0] c_CMD_DOWN  = 3'd2;
    localparam logic [2:0] c_CMD_RIGHT = 3'd3;
    localparam logic [2:0] c_CMD_FEED  = 3'd4;
    localparam logic [2:0] c_CMD_PLAY  = 3'd5;
    localparam logic [2:0] c_CMD_HEAL  = 3'd6;

    // FSM states
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_PRESSED = 2'd1;
    localparam logic [1:0] c_ST_REPEAT  = 2'd2;

    logic [7:0]         r_raw_q;
    logic [c_DEB_W-1:0] r_deb_cnt;
    logic [7:0]         r_stable_key;
    logic               r_fc_q;
    logic [1:0]         r_state;
    logic [7:0]         r_rep_cnt;
    logic [2:0]         r_key_cmd;
    logic               r_key_move;
    logic [2:0]         r_mem [0:1];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_count;
    logic               r_overflow;

    logic       w_deb_fire;
    logic       w_new_key;
    logic       w_tick;
    logic       w_map_valid;
    logic [2:0] w_map_cmd;
    logic       w_map_move;
    logic [7:0] w_rep_next;
    logic       w_push;
    logic [2:0] w_push_cmd;
    logic       w_pop;
    logic       w_wr;

    // The value being accepted is raw_q; a change of stable_key is a new press/release
    assign w_deb_fire = (r_deb_cnt == c_DEB_LAST) && (keycode == r_raw_q);
    assign w_new_key  = w_deb_fire && (r_raw_q != r_stable_key);
    assign w_tick     = frame_clk & ~r_fc_q;
    assign w_rep_next = r_rep_cnt + 8'd1;
    assign w_map_move = w_map_valid && (w_map_cmd <= c_CMD_RIGHT);

    // Keycode-to-command lookup for the key about to become stable
    always_comb begin
        w_map_valid = 1'b1;
        w_map_cmd   = c_CMD_UP;
        case (r_raw_q)
            8'h1A:   w_map_cmd = c_CMD_UP;
            8'h04:   w_map_cmd = c_CMD_LEFT;
            8'h16:   w_map_cmd = c_CMD_DOWN;
            8'h07:   w_map_cmd = c_CMD_RIGHT;
            8'h09:   w_map_cmd = c_CMD_FEED;
            8'h13:   w_map_cmd = c_CMD_PLAY;
            8'h0B:   w_map_cmd = c_CMD_HEAL;
            default: w_map_valid = 1'b0;
        endcase
    end

    // Input sampling, debounce counter and stable key register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_raw_q      <= 8'h00;
            r_deb_cnt    <= '0;
            r_stable_key <= 8'h00;
            r_fc_q       <= 1'b0;
        end else begin
            r_raw_q <= keycode;
            r_fc_q  <= frame_clk;
            if (keycode != r_raw_q) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt != c_DEB_SAT) begin
                r_deb_cnt <= r_deb_cnt + c_DEB_W'(1);
            end
            if (w_deb_fire) begin
                r_stable_key <= r_raw_q;
            end
        end
    end

    // Push request: new press on the debounce edge, repeats on qualifying ticks
    always_comb begin
        w_push     = 1'b0;
        w_push_cmd = r_key_cmd;
        if (w_new_key) begin
            w_push     = w_map_valid;
            w_push_cmd = w_map_cmd;
        end else if (w_tick) begin
            if (r_state == c_ST_PRESSED && r_key_move && w_rep_next == c_REP_DELAY) begin
                w_push = 1'b1;
            end
            if (r_state == c_ST_REPEAT && w_rep_next == c_REP_RATE) begin
                w_push = 1'b1;
            end
        end
    end

    // Press/repeat state machine; a stable_key change always restarts it
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= c_ST_IDLE;
            r_rep_cnt  <= 8'd0;
            r_key_cmd  <= c_CMD_UP;
            r_key_move <= 1'b0;
        end else if (w_new_key) begin
            r_rep_cnt <= 8'd0;
            if (w_map_valid) begin
                r_state    <= c_ST_PRESSED;
                r_key_cmd  <= w_map_cmd;
                r_key_move <= w_map_move;
            end else begin
                r_state <= c_ST_IDLE;
            end
        end else if (w_tick) begin
            case (r_state)
                c_ST_PRESSED: begin
                    if (r_key_move) begin
                        if (w_rep_next == c_REP_DELAY) begin
                            r_state   <= c_ST_REPEAT;
                            r_rep_cnt <= 8'd0;
                        end else begin
                            r_rep_cnt <= w_rep_next;
                        end
                    end
                end
                c_ST_REPEAT: begin
                    if (w_rep_next == c_REP_RATE) begin
                        r_rep_cnt <= 8'd0;
                    end else begin
                        r_rep_cnt <= w_rep_next;
                    end
                end
                default: begin
                    r_rep_cnt <= 8'd0;
                end
            endcase
        end
    end

    // When full, wr_ptr equals rd_ptr, so a simultaneous pop frees exactly the slot written
    assign w_pop = (r_count != 2'd0) && cmd_ready;
    assign w_wr  = w_push && ((r_count != 2'd2) || w_pop);

    // Two-entry command FIFO with sticky overflow flag
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_mem[0]   <= 3'd0;
            r_mem[1]   <= 3'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_push_cmd;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_wr} - {1'b0, w_pop};
            if (w_push && !w_wr) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign cmd_valid  = (r_count != 2'd0);
    assign cmd        = cmd_valid ? r_mem[r_rd_ptr] : 3'd0;
    assign overflow   = r_overflow;
    assign stable_key = r_stable_key;

endmodule
`default_nettype wire
